// File: rtl/nes_pkg.sv
// Shared definitions for the NES core's small glue blocks: the edge-select
// encoding, legal parameter limits and the edge qualifier shared by the pulse
// generators.
package nes_pkg;

  // Which transition of the watched level should launch a pulse.
  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_sel_t;

  // Longest pulse a pulse generator may be configured for, in clk cycles.
  localparam int MAX_PULSE_LEN = 255;

  // Deepest input synchronizer a pulse generator may be configured with.
  localparam int MAX_SYNC_STAGES = 3;

  // Qualify the current sample against the previous one for the chosen edge.
  function automatic logic edge_hit(input edge_sel_t sel,
                                    input logic      cur,
                                    input logic      prev);
    logic rise;
    logic fall;
    logic hit;
    rise = cur & ~prev;
    fall = ~cur & prev;
    hit  = 1'b0;
    case (sel)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      EDGE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_pulse_gen_sync_chain.sv
// Plain flip-flop synchronizer for one bit. Each stage adds exactly one clk
// cycle of latency; the last stage is the synchronized output.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the input through the stage registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/edge_pulse_gen.sv
// Edge-to-pulse converter. Watches level input s (optionally synchronized
// into clk first) and emits a registered pulse p of PULSE_LEN cycles on each
// qualifying edge. A new edge while p is active reloads the length, so pulses
// stretch rather than split. In the NES core this turns the PPU vblank level
// into a single NMI request for the CPU.
module edge_pulse_gen
  import nes_pkg::*;
#(
  parameter int EDGE        = 0,
  parameter int SYNC_STAGES = 0,
  parameter int PULSE_LEN   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  output logic p
);

  localparam int        CW       = $clog2(PULSE_LEN + 1);
  localparam logic [CW-1:0] LEN_C = CW'(PULSE_LEN);
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam edge_sel_t EDGE_SEL = edge_sel_t'(EDGE[1:0]);

  // Refuse to build with a configuration the logic below does not cover.
  if (EDGE < 0 || EDGE > 2) begin : g_bad_edge
    $fatal(1, "edge_pulse_gen: EDGE must be 0, 1 or 2");
  end
  if (SYNC_STAGES < 0 || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
    $fatal(1, "edge_pulse_gen: SYNC_STAGES must be 0..3");
  end
  if (PULSE_LEN < 1 || PULSE_LEN > MAX_PULSE_LEN) begin : g_bad_len
    $fatal(1, "edge_pulse_gen: PULSE_LEN must be 1..255");
  end

  logic          ss;
  logic          s_q;
  logic          det;
  logic [CW-1:0] cnt;

  // Bring s into the clk domain when it comes from elsewhere; otherwise use it as-is.
  if (SYNC_STAGES > 0) begin : g_sync
    sync_chain #(
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (s),
      .q     (ss)
    );
  end else begin : g_nosync
    assign ss = s;
  end

  // Compare the fresh sample with last cycle's to find the selected edge.
  always_comb begin
    det = 1'b0;
    det = edge_hit(EDGE_SEL, ss, s_q);
  end

  // Remember the sample and run the pulse length counter; s_q starts at 0 so a
  // level already high at reset release still counts as a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= 1'b0;
      cnt <= '0;
      p   <= 1'b0;
    end else begin
      s_q <= ss;
      if (det) begin
        cnt <= LEN_C;
        p   <= 1'b1;
      end else if (cnt == ONE_C) begin
        cnt <= '0;
        p   <= 1'b0;
      end else if (cnt != '0) begin
        cnt <= cnt - ONE_C;
      end
    end
  end

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Directed bench for edge_pulse_gen: five instances cover edge polarity,
// synchronizer latency, pulse length, retrigger and reset behaviour.
module tb_edge_pulse_gen;

  logic clk;
  logic rst_n;
  logic s;
  logic s3;
  logic s4;
  logic p0, p1, p2, p3, p4;

  int total;
  int bad;

  // Defaults: rising edge, no sync, 1-cycle pulse.
  edge_pulse_gen #(.EDGE(0), .SYNC_STAGES(0), .PULSE_LEN(1)) d0 (
    .clk(clk), .rst_n(rst_n), .s(s), .p(p0));
  // Falling edge.
  edge_pulse_gen #(.EDGE(1), .SYNC_STAGES(0), .PULSE_LEN(1)) d1 (
    .clk(clk), .rst_n(rst_n), .s(s), .p(p1));
  // Both edges.
  edge_pulse_gen #(.EDGE(2), .SYNC_STAGES(0), .PULSE_LEN(1)) d2 (
    .clk(clk), .rst_n(rst_n), .s(s), .p(p2));
  // Two-stage synchronizer, 4-cycle pulse.
  edge_pulse_gen #(.EDGE(0), .SYNC_STAGES(2), .PULSE_LEN(4)) d3 (
    .clk(clk), .rst_n(rst_n), .s(s3), .p(p3));
  // No synchronizer, 4-cycle pulse (retrigger / reset cases).
  edge_pulse_gen #(.EDGE(0), .SYNC_STAGES(0), .PULSE_LEN(4)) d4 (
    .clk(clk), .rst_n(rst_n), .s(s4), .p(p4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s  = 1'b0;
    s3 = 1'b0;
    s4 = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({p0, p1, p2, p3, p4} !== 5'b00000) begin
        bad++;
        $display("[TB] FAIL reset_state cyc=%0d got p0..p4=%b want 00000", i,
                 {p0, p1, p2, p3, p4});
      end
      step();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_edge_modes();
    logic e0, e1, e2;
    for (int i = 0; i < 40; i++) begin
      s = (i >= 10 && i < 30);
      step();
      e0 = (i == 10);
      e1 = (i == 30);
      e2 = (i == 10) || (i == 30);
      total++;
      if (p0 !== e0) begin
        bad++;
        $display("[TB] FAIL rise_pulse cyc=%0d got p=%b want %b", i, p0, e0);
      end
      total++;
      if (p1 !== e1) begin
        bad++;
        $display("[TB] FAIL fall_pulse cyc=%0d got p=%b want %b", i, p1, e1);
      end
      total++;
      if (p2 !== e2) begin
        bad++;
        $display("[TB] FAIL both_pulse cyc=%0d got p=%b want %b", i, p2, e2);
      end
    end
  endtask

  task automatic test_sync_len();
    logic e3;
    for (int i = 0; i < 10; i++) begin
      s3 = 1'b1;
      step();
      e3 = (i >= 2 && i <= 5);
      total++;
      if (p3 !== e3) begin
        bad++;
        $display("[TB] FAIL sync2_len4 cyc=%0d got p=%b want %b", i, p3, e3);
      end
    end
    s3 = 1'b0;
    step();
    step();
  endtask

  task automatic test_back_to_back();
    logic e4;
    for (int i = 0; i < 10; i++) begin
      s4 = (i != 1);
      step();
      e4 = (i <= 5);
      total++;
      if (p4 !== e4) begin
        bad++;
        $display("[TB] FAIL retrigger cyc=%0d got p=%b want %b", i, p4, e4);
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    s4 = 1'b0;
    step();
    s4 = 1'b1;
    step();
    total++;
    if (p4 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midpulse_setup got p=%b want 1", p4);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (p4 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_reset got p=%b want 0", p4);
    end
    s4 = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (p4 !== 1'b0) begin
        bad++;
        $display("[TB] FAIL no_resume cyc=%0d got p=%b want 0", i, p4);
      end
    end
  endtask

  task automatic test_release_high();
    logic e0, e2, e3, e4;
    rst_n = 1'b0;
    s  = 1'b1;
    s3 = 1'b1;
    s4 = 1'b1;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 105; i++) begin
      step();
      e0 = (i == 0);
      e2 = (i == 0);
      e3 = (i >= 2 && i <= 5);
      e4 = (i <= 3);
      total++;
      if (p0 !== e0) begin
        bad++;
        $display("[TB] FAIL release_rise cyc=%0d got p=%b want %b", i, p0, e0);
      end
      total++;
      if (p1 !== 1'b0) begin
        bad++;
        $display("[TB] FAIL release_fall cyc=%0d got p=%b want 0", i, p1);
      end
      total++;
      if (p2 !== e2) begin
        bad++;
        $display("[TB] FAIL release_both cyc=%0d got p=%b want %b", i, p2, e2);
      end
      total++;
      if (p3 !== e3) begin
        bad++;
        $display("[TB] FAIL release_sync2 cyc=%0d got p=%b want %b", i, p3, e3);
      end
      total++;
      if (p4 !== e4) begin
        bad++;
        $display("[TB] FAIL release_len4 cyc=%0d got p=%b want %b", i, p4, e4);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_edge_modes();
    test_sync_len();
    test_back_to_back();
    test_reset_mid_pulse();
    test_release_high();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want test completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/edge_pulse_gen.md
Name: edge_pulse_gen

Overview:
- Synchronous edge detector that turns a level signal `s` into a clean pulse `p` of fixed length.
- Used in the NES core to convert the PPU vblank/NMI level into a single-cycle NMI request for the 6502 core.
- Optional input synchronizer, selectable edge polarity, configurable pulse length.

Parameters:
- EDGE, 0: edge that triggers a pulse. 0 = rising, 1 = falling, 2 = both.
- SYNC_STAGES, 0: number of flip-flop synchronizer stages on `s` (0..3). 0 means `s` is already in the `clk` domain.
- PULSE_LEN, 1: width of `p` in clk cycles (1..255).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- s  input  1  level input to watch.
- p  output  1  pulse output, registered.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all synchronizer stages, the previous-sample register `s_q` and the pulse counter clear to 0;
  - `p`=0 immediately.
- Sampled value `ss`:
  - SYNC_STAGES=0: `ss` = s;
  - otherwise `ss` = output of the last synchronizer stage. Each stage adds exactly 1 cycle of latency.
- Every clk edge: `s_q` <= `ss`.
- Edge detect (combinational):
  - rise = ss & ~s_q;
  - fall = ~ss & s_q;
  - det = rise (EDGE=0), fall (EDGE=1), rise|fall (EDGE=2).
- Pulse generation:
  - on the clk edge where det=1, counter <= PULSE_LEN and `p` <= 1;
  - while counter>1 and det=0: counter decrements and `p` stays 1;
  - when counter reaches 1 with det=0: counter <= 0 and `p` <= 0.
  - `p` is therefore high for exactly PULSE_LEN cycles.
- Latency: with SYNC_STAGES=0, if `s` is first sampled high at edge E, then `p`=1 from edge E+1 to edge E+1+PULSE_LEN. Each synchronizer stage adds 1 cycle.
- Retrigger: a new qualifying edge while `p` is active reloads the counter to PULSE_LEN, extending the pulse. There is no gap and no double pulse.
- Level held high: exactly one pulse per qualifying edge. A level held for any duration never produces a repeat.
- Reset released with `s` already high: `s_q`=0, so EDGE 0 or 2 produces one pulse on the first sampled cycle. This is intentional: a pending NMI level is not lost.
- Glitch of 1 cycle (0->1->0) with EDGE=0: one full PULSE_LEN pulse.
- Reset asserted mid-pulse: `p` drops to 0 immediately, the counter clears, and no pulse resumes after release unless a new edge occurs.
- Illegal values are out of scope and need no handling beyond the elaboration check below: EDGE>2, PULSE_LEN=0, SYNC_STAGES>3.
- Elaboration-time assertion on illegal parameter values.

Decomposition:
- Shared package `nes_pkg`:
  - enum edge_sel_t {EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2};
  - constant MAX_PULSE_LEN=255.
- One natural sub-module: `sync_chain` (parameter STAGES, async active-low reset, 1-bit). It is instantiated only when SYNC_STAGES>0 and is otherwise a pass-through generate branch.
- Counter width is $clog2(PULSE_LEN+1).

Test Plan:
- Defaults (EDGE=0, SYNC=0, LEN=1):
  - stimulus: `s` 0 for 10 cycles, 1 for 20 cycles, then 0;
  - required: `p`=1 for exactly 1 cycle, 1 clk after `s` is first sampled high;
  - required: no pulse on the fall; `p`=0 at all other times.
- EDGE=1 and EDGE=2, same stimulus:
  - EDGE=1: a single pulse 1 cycle after the fall only;
  - EDGE=2: two 1-cycle pulses, 20 cycles apart.
- LEN=4, SYNC=2:
  - stimulus: rising edge of `s`;
  - required: `p` high for exactly 4 cycles, starting 3 clks after `s` is first high at the clk edge.
- LEN=4, retrigger:
  - stimulus: `s` pulses 0->1 at cycle 0, back to 0 at cycle 1, 0->1 again at cycle 2;
  - required: `p` continuously high for 6 cycles, with no gap.
- Reset:
  - stimulus: rst_n=0 mid-pulse;
  - required: `p`=0 asynchronously, before the next clk edge.
- Reset release with `s`=1:
  - stimulus: release rst_n while `s`=1;
  - required: exactly one pulse, then silence while `s` stays 1 for 100 cycles.
